servo_pwm_multi: RTL and testbench
==================================

Name: servo_pwm_multi

Overview:
Parametrised multi-channel servo PWM generator, successor to the single-output pwm_out stage of Servo_Top. It accepts per-channel 8-bit position commands over a valid/ready write port and drives N_CH frame-aligned PWM outputs. Each channel has a per-frame slew limit, and updates are glitch-free because pulse widths change only at frame boundaries. It sits between the control/PID stage and the servo pins.

Parameters:
N_CH, 2, number of PWM channels (1..16)
CH_W, 1, width of channel index (>= clog2(N_CH), min 1)
CMD_W, 8, position command width
PERIOD_CNT, 2000000, frame length in clocks (20 ms at 100 MHz)
PULSE_MIN, 100000, pulse width in clocks for command 0 (1 ms)
PULSE_STEP, 392, clocks added per command LSB
SLEW_MAX, 4, max change of applied position per frame, in command LSBs; 0 = unlimited
CENTER, 128, reset position for every channel

Ports:
Clock_Nexys  in  1  system clock
Reset  in  1  synchronous, active-high reset
enable  in  1  output enable, sampled at frame start
cmd_valid  in  1  command write strobe
cmd_ch  in  CH_W  target channel index
cmd_data  in  CMD_W  target position
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_err  out  1  one-cycle pulse: write to channel index >= N_CH
frame_start  out  1  one-cycle pulse at start of each frame
pwm_out  out  N_CH  servo pulse outputs
position  out  N_CH*CMD_W  applied position per channel, channel i at [i*CMD_W +: CMD_W]

Behaviour:
- Decided: one clock (Clock_Nexys). Reset is synchronous and active-high (Reset).
- Reset values:
  - frame counter = 0
  - targets and applied positions = CENTER
  - pwm_out = 0, frame_start = 0, cmd_err = 0, cmd_ready = 0
  - internal enable latch = 0
- cmd_ready is 1 in every cycle after reset deasserts. A write occurs when cmd_valid && cmd_ready.
  - Valid index: target[cmd_ch] <= cmd_data. Takes effect at the next frame update.
  - Index >= N_CH: no state change; cmd_err = 1 in the following cycle.
  - Multiple writes within one frame: the last write wins.
- Frame counter cnt runs 0..PERIOD_CNT-1 and wraps to 0.
- Frame update, in the cycle cnt==PERIOD_CNT-1, for each channel i:
  - d = target - applied (signed).
  - If SLEW_MAX==0 or |d| <= SLEW_MAX: applied = target. Otherwise applied moves SLEW_MAX toward target.
  - The enable latch is loaded from enable.
  - A write in the same cycle as the update is not seen by that update; it applies at the following frame.
- Pulse width W_i = PULSE_MIN + applied_i*PULSE_STEP, computed in ceil(log2(PERIOD_CNT))+1 bits.
  - If W_i >= PERIOD_CNT, the pulse saturates to PERIOD_CNT-1 clocks (output never stays high across a frame).
- Registered outputs:
  - frame_start = 1 in the cycle after cnt==0 is evaluated.
  - pwm_out[i] = enable_latch && (cnt < W_i), registered.
  - Result: pwm_out[i] rises in the same cycle frame_start is high and stays high exactly W_i cycles.
- enable changes mid-frame have no effect until the next frame start. No runt pulses: outputs are never truncated or extended mid-frame.
- position reflects applied values and updates the cycle after the frame update.
- Reset asserted mid-pulse: pwm_out = 0 next cycle, all state returns to reset values, and the frame restarts from cnt=0 after release.

Test Plan:
Bench parameters for all scenarios: N_CH=2, CH_W=1, PERIOD_CNT=1000, PULSE_MIN=100, PULSE_STEP=2, SLEW_MAX=16, CENTER=128.
1. Reset, enable=1 -> first frame after enable latches: both pwm_out high 356 cycles, frame_start every 1000 cycles, position = {128,128}.
2. Write ch0=255 -> applied ch0 steps 144,160,...,240,255 over 8 frames; final pulse 610 cycles; ch1 unchanged at 356.
3. SLEW_MAX=0 variant, write ch1=0 -> next frame pulse 100 cycles; write ch1=255 at cnt==999 -> applied at the frame after next, not the next.
4. cmd_ch=1 with N_CH=1 build -> cmd_err pulses one cycle, no position change; PULSE_STEP=4 with cmd 255 -> W=1120 saturates to 999-cycle pulse.
5. Drop enable at cnt=50 -> current pulse completes the full 356 cycles; next frame pwm_out stays 0; re-enable mid-frame -> pulses resume at the following frame.
6. Assert Reset at cnt=200 during a pulse -> pwm_out=0 next cycle, position={128,128}, cmd_ready=0 during reset, frame restarts at cnt=0 after release.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel frame-aligned servo PWM generator with per-frame slew limit
module servo_pwm_multi #(
  parameter int N_CH       = 2,
  parameter int CH_W       = 1,
  parameter int CMD_W      = 8,
  parameter int PERIOD_CNT = 2000000,
  parameter int PULSE_MIN  = 100000,
  parameter int PULSE_STEP = 392,
  parameter int SLEW_MAX   = 4,
  parameter int CENTER     = 128
) (
  input  logic                  Clock_Nexys,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic                  cmd_valid,
  input  logic [CH_W-1:0]       cmd_ch,
  input  logic [CMD_W-1:0]      cmd_data,
  output logic                  cmd_ready,
  output logic                  cmd_err,
  output logic                  frame_start,
  output logic [N_CH-1:0]       pwm_out,
  output logic [N_CH*CMD_W-1:0] position
);
  localparam int PW = $clog2(PERIOD_CNT) + 1;
  localparam int DW = CMD_W + 1;
  localparam logic [PW-1:0]    LAST_V   = PW'(PERIOD_CNT - 1);
  localparam logic [PW-1:0]    PERIOD_V = PW'(PERIOD_CNT);
  localparam logic [PW-1:0]    MIN_V    = PW'(PULSE_MIN);
  localparam logic [PW-1:0]    STEP_V   = PW'(PULSE_STEP);
  localparam logic [DW-1:0]    SLEW_V   = DW'(SLEW_MAX);
  localparam logic [CMD_W-1:0] SLEW_C   = CMD_W'(SLEW_MAX);
  localparam logic [CMD_W-1:0] CENTER_V = CMD_W'(CENTER);

  logic [PW-1:0]        cnt;
  logic                 en_latch;
  logic [CMD_W-1:0]     target    [N_CH];
  logic [CMD_W-1:0]     applied   [N_CH];
  logic [CMD_W-1:0]     next_app  [N_CH];
  logic signed [DW-1:0] diff      [N_CH];
  logic [DW-1:0]        mag       [N_CH];
  logic [PW-1:0]        width     [N_CH];
  logic [PW-1:0]        width_sat [N_CH];
  logic                 frame_end;
  logic                 wr;
  logic                 ch_ok;

  assign frame_end = (cnt == LAST_V);
  assign wr        = cmd_valid && cmd_ready;
  assign ch_ok     = (int'(cmd_ch) < N_CH);

  // Slew step toward target and pulse width, both from the currently applied position
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      diff[i] = $signed({1'b0, target[i]}) - $signed({1'b0, applied[i]});
      mag[i]  = diff[i][DW-1] ? $unsigned(-diff[i]) : $unsigned(diff[i]);
      if (SLEW_MAX == 0 || mag[i] <= SLEW_V) begin
        next_app[i] = target[i];
      end else if (diff[i][DW-1]) begin
        next_app[i] = applied[i] - SLEW_C;
      end else begin
        next_app[i] = applied[i] + SLEW_C;
      end
      width[i]     = MIN_V + PW'(applied[i]) * STEP_V;
      width_sat[i] = (width[i] >= PERIOD_V) ? LAST_V : width[i];
    end
  end

  always_comb begin
    position = '0;
    for (int i = 0; i < N_CH; i++) begin
      position[i*CMD_W +: CMD_W] = applied[i];
    end
  end

  always_ff @(posedge Clock_Nexys) begin
    if (Reset) begin
      cnt         <= '0;
      en_latch    <= 1'b0;
      cmd_ready   <= 1'b0;
      cmd_err     <= 1'b0;
      frame_start <= 1'b0;
      pwm_out     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        target[i]  <= CENTER_V;
        applied[i] <= CENTER_V;
      end
    end else begin
      cmd_ready   <= 1'b1;
      cmd_err     <= wr && !ch_ok;
      frame_start <= (cnt == '0);
      cnt         <= frame_end ? '0 : cnt + 1'b1;
      if (frame_end) begin
        en_latch <= enable;
      end
      // Applied positions and the enable latch only move at the frame boundary, so a pulse
      // in flight is never truncated or stretched.
      for (int i = 0; i < N_CH; i++) begin
        if (frame_end) begin
          applied[i] <= next_app[i];
        end
        if (wr && ch_ok && cmd_ch == CH_W'(i)) begin
          target[i] <= cmd_data;
        end
        pwm_out[i] <= en_latch && (cnt < width_sat[i]);
      end
    end
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - self-checking bench for servo_pwm_multi with a frame-level reference model
module tb_servo_pwm_multi;
  localparam int P = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       cv [3];
  logic       cc [3];
  logic [7:0] cd [3];

  logic       rdy [3];
  logic       err [3];
  logic       fs  [3];
  logic [1:0]  pwm_a, pwm_b;
  logic [0:0]  pwm_c;
  logic [15:0] pos_a, pos_b;
  logic [7:0]  pos_c;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  int m_t;
  int m_app [3][2];
  int m_tgt [3][2];
  bit m_lat [3];
  bit m_err [3];
  int run   [3][2];
  int lastw [3][2];

  always #5 clk = ~clk;

  servo_pwm_multi #(.N_CH(2), .CH_W(1), .CMD_W(8), .PERIOD_CNT(P), .PULSE_MIN(100),
                    .PULSE_STEP(2), .SLEW_MAX(16), .CENTER(128)) dut_a (
    .Clock_Nexys(clk), .Reset(rst), .enable(enable), .cmd_valid(cv[0]), .cmd_ch(cc[0]),
    .cmd_data(cd[0]), .cmd_ready(rdy[0]), .cmd_err(err[0]), .frame_start(fs[0]),
    .pwm_out(pwm_a), .position(pos_a));

  servo_pwm_multi #(.N_CH(2), .CH_W(1), .CMD_W(8), .PERIOD_CNT(P), .PULSE_MIN(100),
                    .PULSE_STEP(2), .SLEW_MAX(0), .CENTER(128)) dut_b (
    .Clock_Nexys(clk), .Reset(rst), .enable(enable), .cmd_valid(cv[1]), .cmd_ch(cc[1]),
    .cmd_data(cd[1]), .cmd_ready(rdy[1]), .cmd_err(err[1]), .frame_start(fs[1]),
    .pwm_out(pwm_b), .position(pos_b));

  servo_pwm_multi #(.N_CH(1), .CH_W(1), .CMD_W(8), .PERIOD_CNT(P), .PULSE_MIN(100),
                    .PULSE_STEP(4), .SLEW_MAX(0), .CENTER(128)) dut_c (
    .Clock_Nexys(clk), .Reset(rst), .enable(enable), .cmd_valid(cv[2]), .cmd_ch(cc[2]),
    .cmd_data(cd[2]), .cmd_ready(rdy[2]), .cmd_err(err[2]), .frame_start(fs[2]),
    .pwm_out(pwm_c), .position(pos_c));

  function automatic int nch(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int step(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic int slew(input int d);
    return (d == 0) ? 16 : 0;
  endfunction

  function automatic int wsat(input int d, input int a);
    int w;
    w = 100 + a * step(d);
    return (w >= P) ? P - 1 : w;
  endfunction

  function automatic logic pwm_of(input int d, input int i);
    case (d)
      0:       return pwm_a[i];
      1:       return pwm_b[i];
      default: return pwm_c[0];
    endcase
  endfunction

  function automatic logic [7:0] pos_of(input int d, input int i);
    case (d)
      0:       return pos_a[i*8 +: 8];
      1:       return pos_b[i*8 +: 8];
      default: return pos_c;
    endcase
  endfunction

  function automatic logic e_pwm(input int d, input int i);
    if (m_t < 1 || !m_lat[d]) return 1'b0;
    return ((m_t - 1) % P) < wsat(d, m_app[d][i]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", nm, m_t, act, exp);
    end
  endtask

  // Reference model: time since reset release, positions updated once per frame
  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      for (int d = 0; d < 3; d++) begin
        m_lat[d] = 0;
        m_err[d] = 0;
        for (int i = 0; i < 2; i++) begin
          m_app[d][i] = 128;
          m_tgt[d][i] = 128;
        end
      end
    end else begin
      bit acc [3];
      for (int d = 0; d < 3; d++) acc[d] = cv[d] && (m_t >= 1);
      m_t = m_t + 1;
      if (m_t % P == 0) begin
        for (int d = 0; d < 3; d++) begin
          m_lat[d] = enable;
          for (int i = 0; i < nch(d); i++) begin
            int dl;
            dl = m_tgt[d][i] - m_app[d][i];
            if (slew(d) == 0 || (dl <= slew(d) && -dl <= slew(d))) m_app[d][i] = m_tgt[d][i];
            else if (dl > 0) m_app[d][i] = m_app[d][i] + slew(d);
            else m_app[d][i] = m_app[d][i] - slew(d);
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        m_err[d] = acc[d] && (int'(cc[d]) >= nch(d));
        if (acc[d] && int'(cc[d]) < nch(d)) m_tgt[d][int'(cc[d])] = int'(cd[d]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < nch(d); i++) begin
          check($sformatf("pwm%0d_%0d", d, i), 32'(pwm_of(d, i)), 32'(e_pwm(d, i)));
          check($sformatf("pos%0d_%0d", d, i), 32'(pos_of(d, i)), 32'(m_app[d][i]));
        end
        check($sformatf("frame_start%0d", d), 32'(fs[d]), 32'(m_t % P == 1));
        check($sformatf("cmd_ready%0d", d), 32'(rdy[d]), 32'(m_t >= 1));
        check($sformatf("cmd_err%0d", d), 32'(err[d]), 32'(m_err[d]));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < nch(d); i++) begin
          if (pwm_of(d, i) === 1'b1) begin
            run[d][i]++;
          end else begin
            if (run[d][i] > 0) lastw[d][i] = run[d][i];
            run[d][i] = 0;
          end
        end
      end
    end
  end

  task automatic wait_t(input int n);
    int budget;
    budget = 0;
    while (m_t != n && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (m_t != n) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_t: got t=%0d expected t=%0d", m_t, n);
    end
  endtask

  task automatic wr(input int d, input int ch, input int val);
    cv[d] = 1'b1;
    cc[d] = 1'(ch);
    cd[d] = 8'(val);
    @(posedge clk);
    @(negedge clk);
    cv[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cv[d] = 1'b0;
      cc[d] = 1'b0;
      cd[d] = 8'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1;
    check("rst_pwm_a", 32'(pwm_a), 32'd0);
    check("rst_pos_a", 32'(pos_a), 32'h8080);
    check("rst_ready_a", 32'(rdy[0]), 32'd0);
    rst = 1'b0;

    wait_t(500);
    check("no_pulse_before_latch", 32'(pwm_a), 32'd0);
    wait_t(1001);
    check("first_frame_fs", 32'(fs[0]), 32'd1);
    check("first_frame_pwm", 32'(pwm_a), 32'd3);

    wait_t(1500);
    wr(0, 0, 255);
    wr(1, 1, 0);
    wr(2, 1, 77);
    check("err_pulse_c", 32'(err[2]), 32'd1);
    check("err_nopos_c", 32'(pos_c), 32'd128);
    wr(2, 0, 255);

    wait_t(1900);
    check("w_center_a0", 32'(lastw[0][0]), 32'd356);
    check("w_center_a1", 32'(lastw[0][1]), 32'd356);
    check("w_center_b1", 32'(lastw[1][1]), 32'd356);
    check("w_center_c0", 32'(lastw[2][0]), 32'd612);

    wait_t(2999);
    wr(1, 1, 255);
    wait_t(3100);
    check("w_slew1_a0", 32'(lastw[0][0]), 32'd388);
    check("pos_slew2_a0", 32'(pos_a[7:0]), 32'd160);
    check("w_zero_b1", 32'(lastw[1][1]), 32'd100);
    check("w_sat_c0", 32'(lastw[2][0]), 32'd999);

    wait_t(3900);
    check("w_late_write_b1", 32'(lastw[1][1]), 32'd100);
    check("w_slew2_a0", 32'(lastw[0][0]), 32'd420);
    wait_t(4900);
    check("w_late_applied_b1", 32'(lastw[1][1]), 32'd610);

    wait_t(9900);
    check("w_final_a0", 32'(lastw[0][0]), 32'd610);
    check("w_final_a1", 32'(lastw[0][1]), 32'd356);
    check("pos_final_a", 32'(pos_a), 32'h80FF);

    wait_t(10050);
    enable = 1'b0;
    wait_t(10900);
    check("w_full_after_drop_a1", 32'(lastw[0][1]), 32'd356);
    wait_t(11500);
    check("disabled_pwm_a", 32'(pwm_a), 32'd0);
    enable = 1'b1;
    wait_t(11990);
    check("reenable_wait_pwm_a", 32'(pwm_a), 32'd0);
    wait_t(12100);
    check("reenable_pwm_a", 32'(pwm_a), 32'd3);

    wait_t(13200);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm_a", 32'(pwm_a), 32'd0);
    check("rst_mid_pos_a", 32'(pos_a), 32'h8080);
    check("rst_mid_ready_a", 32'(rdy[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_t(1);
    check("restart_fs", 32'(fs[0]), 32'd1);
    check("restart_pwm", 32'(pwm_a), 32'd0);
    wait_t(1100);
    check("restart_pulse", 32'(pwm_a), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
